sw_debounce: RTL and testbench



---
 rtl/sw_debounce_pkg.sv | 21 ++
 rtl/sw_debounce_bit.sv | 101 ++++++++++
 rtl/sw_debounce.sv | 46 ++++
 tb/tb_sw_debounce.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the mux-lab switch conditioning path: the switch
// word width, the data/select field split and the per-bit debounce states.
package sw_pkg;

  // Total number of board switches conditioned for the mux lab.
  localparam int unsigned SW_WIDTH    = 6;

  // Bits [3:0] feed the mux data input, bits [5:4] feed its select.
  localparam int unsigned SW_DATA_LSB = 0;
  localparam int unsigned SW_DATA_MSB = 3;
  localparam int unsigned SW_SEL_LSB  = 4;
  localparam int unsigned SW_SEL_MSB  = 5;

  // Per-bit debounce state: output agrees with input, or a disagreement
  // is being timed.
  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-bit conditioner: two-flop synchroniser followed by a stability
// counter. The output only follows the synchronised input once the two have
// disagreed for STABLE_CYCLES consecutive cycles.
module debounce_bit
  import sw_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter logic        RESET_BIT     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic sw_o,
  output logic changed_o,
  output logic changed_next_o
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             sync1_q;
  logic             sync2_q;
  deb_state_t       state_q;
  deb_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             sw_q;
  logic             sw_d;
  logic             chg_q;
  logic             chg_d;

  // Two-stage synchroniser; reset to the output reset level so leaving
  // reset never looks like a switch edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= RESET_BIT;
      sync2_q <= RESET_BIT;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state logic: time a disagreement, drop it if it ends early,
  // flip the output once it has lasted STABLE_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sw_d    = sw_q;
    chg_d   = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync2_q != sw_q) begin
          state_d = ST_COUNTING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_COUNTING: begin
        if (sync2_q == sw_q) begin
          state_d = ST_STABLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_STABLE;
          cnt_d   = CNT_ZERO;
          sw_d    = sync2_q;
          chg_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered outputs; reset discards any count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_STABLE;
      cnt_q   <= CNT_ZERO;
      sw_q    <= RESET_BIT;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sw_q    <= sw_d;
      chg_q   <= chg_d;
    end
  end

  assign sw_o           = sw_q;
  assign changed_o      = chg_q;
  assign changed_next_o = chg_d;

endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning for the 4-to-1 mux lab: one independent debouncer
// per switch bit, plus a registered "any bit changed" strobe.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned      WIDTH         = SW_WIDTH,
  parameter int unsigned      STABLE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VAL     = 6'b000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] changed,
  output logic             any_changed
);

  logic [WIDTH-1:0] changed_d;
  logic             any_changed_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_BIT     (RESET_VAL[g])
    ) u_bit (
      .clk_i          (clk),
      .rst_i          (rst),
      .sw_i           (sw_in[g]),
      .sw_o           (sw_out[g]),
      .changed_o      (changed[g]),
      .changed_next_o (changed_d[g])
    );
  end

  // Summary strobe built from the next-state strobes so it lines up with changed.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_changed_q <= 1'b0;
    end else begin
      any_changed_q <= |changed_d;
    end
  end

  assign any_changed = any_changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce with STABLE_CYCLES=4, RESET_VAL=0.
// Stimulus pushes hand-computed expected events; a negedge monitor pops and
// compares them, and flags any strobe that no event predicted.
module tb_sw_debounce;
  import sw_pkg::*;

  typedef struct {
    string      name;
    int         due;
    logic [5:0] sw;
    logic [5:0] chg;
  } ev_t;

  logic       clk;
  logic       rst;
  logic [5:0] sw_in;
  logic [5:0] sw_out;
  logic [5:0] changed;
  logic       any_changed;

  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t q[$];
  ev_t ev;

  sw_debounce #(
    .WIDTH         (SW_WIDTH),
    .STABLE_CYCLES (4),
    .RESET_VAL     (6'b000000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_in       (sw_in),
    .sw_out      (sw_out),
    .changed     (changed),
    .any_changed (any_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare due events, otherwise strobes must be idle.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due < cyc) begin
      ev = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s event due at edge %0d never checked (now %0d)", ev.name, ev.due, cyc);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      ev = q.pop_front();
      checks++;
      if (sw_out !== ev.sw || changed !== ev.chg || any_changed !== (|ev.chg)) begin
        errors++;
        $display("FAIL %s edge %0d: sw_out=%h want %h, changed=%h want %h, any_changed=%b want %b",
                 ev.name, cyc, sw_out, ev.sw, changed, ev.chg, any_changed, |ev.chg);
      end
    end else begin
      checks++;
      if (changed !== 6'h00 || any_changed !== 1'b0) begin
        errors++;
        $display("FAIL spurious_strobe edge %0d: changed=%h any_changed=%b want 00/0",
                 cyc, changed, any_changed);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // New level first sampled at the next edge, returned as e.
  task automatic drive(input logic [5:0] v, output int e);
    sw_in = v;
    e = cyc + 1;
  endtask

  task automatic expect_at(input string name, input int due, input logic [5:0] sw, input logic [5:0] chg);
    ev_t x;
    x.name = name;
    x.due  = due;
    x.sw   = sw;
    x.chg  = chg;
    q.push_back(x);
  endtask

  initial begin
    int e;
    rst   = 1'b1;
    sw_in = 6'h3F;

    // Reset held two edges with all switches high: outputs stay at RESET_VAL.
    tick(1);
    expect_at("reset_e1", cyc, 6'h00, 6'h00);
    tick(1);
    expect_at("reset_e2", cyc, 6'h00, 6'h00);
    rst = 1'b0;
    e = cyc + 1;
    expect_at("post_reset_hold", e + 5, 6'h00, 6'h00);
    expect_at("post_reset_flip", e + 6, 6'h3F, 6'h3F);
    expect_at("post_reset_after", e + 7, 6'h3F, 6'h00);
    tick(12);

    // Return all bits low.
    drive(6'h00, e);
    expect_at("all_low_flip", e + 6, 6'h00, 6'h3F);
    tick(12);

    // Clean step on bit 0.
    drive(6'h01, e);
    expect_at("step_hold", e + 5, 6'h00, 6'h00);
    expect_at("step_flip", e + 6, 6'h01, 6'h01);
    expect_at("step_after", e + 7, 6'h01, 6'h00);
    tick(12);

    // 3-cycle glitch on bit 2 is rejected.
    drive(6'h05, e);
    tick(3);
    sw_in = 6'h01;
    expect_at("glitch3_hold", e + 7, 6'h01, 6'h00);
    expect_at("glitch3_late", e + 10, 6'h01, 6'h00);
    tick(12);

    // 5-cycle pulse on bit 2 gets through, then flips back.
    drive(6'h05, e);
    tick(5);
    sw_in = 6'h01;
    expect_at("pulse5_flip", e + 6, 6'h05, 6'h04);
    expect_at("pulse5_return", e + 11, 6'h01, 6'h04);
    tick(14);

    // Select bounce: 01,00,01,00 for 2 cycles each, then settles at 01.
    drive(6'h11, e);
    tick(2);
    sw_in = 6'h01;
    tick(2);
    sw_in = 6'h11;
    tick(2);
    sw_in = 6'h01;
    tick(2);
    drive(6'h11, e);
    expect_at("bounce_hold", e + 5, 6'h01, 6'h00);
    expect_at("bounce_flip", e + 6, 6'h11, 6'h10);
    expect_at("bounce_after", e + 7, 6'h11, 6'h00);
    tick(12);

    // Back to zero, then several bits at once.
    drive(6'h00, e);
    expect_at("clear_flip", e + 6, 6'h00, 6'h11);
    tick(12);
    drive(6'h2A, e);
    expect_at("simul_flip", e + 6, 6'h2A, 6'h2A);
    expect_at("simul_after", e + 7, 6'h2A, 6'h00);
    tick(12);
    drive(6'h00, e);
    expect_at("simul_clear", e + 6, 6'h00, 6'h2A);
    tick(12);

    // Mid-count reset on bit 1: count discarded, restarts after release.
    drive(6'h02, e);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_at("midrst_reset", e + 5, 6'h00, 6'h00);
    expect_at("midrst_hold", e + 11, 6'h00, 6'h00);
    expect_at("midrst_flip", e + 12, 6'h02, 6'h02);
    expect_at("midrst_after", e + 13, 6'h02, 6'h00);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 60 && q.size() > 0; i++) tick(1);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events still pending, want 0", q.size());
    end
    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
